// File: rtl/rpn_pop_eval_pkg.sv
// Shared definitions for the RPN calculator: operator codes, pop FSM states,
// and default stack geometry.
package rpn_pop_eval_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RD_B  = 3'd1,
    ST_RD_A  = 3'd2,
    ST_EXEC  = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } state_e;

endpackage

// File: rtl/rpn_pop_eval_alu.sv
// Combinational 8-bit RPN ALU: y = A op B, modulo 2^DATA_W, no flags.
module rpn_pop_eval_alu
  import rpn_pop_eval_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  op_e               op,
  output logic [DATA_W-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_ADD:  y = a + b;
      OP_SUB:  y = a - b;
      OP_MUL:  y = a * b;
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      // Shift amount is only the low three bits of B.
      OP_SHL:  y = a << b[2:0];
      OP_SHR:  y = a >> b[2:0];
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/rpn_pop_eval.sv
// Pop side of the RPN calculator: reads the two top stack entries, writes
// A op B back over A and decrements SP.
//
// state    | meaning
// ---------+--------------------------------------------------
// ST_IDLE  | waiting for start; RAM/SP outputs held at zero
// ST_RD_B  | address SP-1 presented to RAM
// ST_RD_A  | B captured from RAM; address SP-2 presented
// ST_EXEC  | A on RAM data; ALU result registered
// ST_WRITE | result written at SP-2, SP loaded with SP-1
// ST_DONE  | one-cycle done pulse
// ST_ERR   | underflow (SP < 2); sets sticky error
module rpn_pop_eval
  import rpn_pop_eval_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              CLOCK_50,
  input  logic              RESET_N,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] sp_in,
  output logic [ADDR_W-1:0] sp_out,
  output logic              sp_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] result
);

  state_e            state_q, state_d;
  op_e               op_q;
  logic [ADDR_W-1:0] sp_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic [DATA_W-1:0] alu_y;
  logic              error_q;
  logic              sp_ok;

  assign sp_ok = (sp_in >= ADDR_W'(2));

  rpn_pop_eval_alu #(.DATA_W(DATA_W)) u_alu (
    .a  (ram_rdata),
    .b  (b_q),
    .op (op_q),
    .y  (alu_y)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!RESET_N) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_ADD;
      sp_q     <= '0;
      b_q      <= '0;
      result_q <= '0;
      error_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start && sp_ok) begin
            op_q    <= op_e'(op);
            sp_q    <= sp_in;
            error_q <= 1'b0;
          end
        end
        ST_RD_A: b_q      <= ram_rdata;
        ST_EXEC: result_q <= alu_y;
        ST_ERR:  error_q  <= 1'b1;
        default: ;
      endcase
    end
  end

  // Write strobes are qualified by RESET_N so a reset landing on WRITE
  // leaves both the stack and SP untouched.
  always_comb begin
    state_d   = state_q;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    sp_out    = '0;
    sp_we     = 1'b0;
    done      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = sp_ok ? ST_RD_B : ST_ERR;
      end
      ST_RD_B: begin
        ram_addr = sp_q - ADDR_W'(1);
        state_d  = ST_RD_A;
      end
      ST_RD_A: begin
        ram_addr = sp_q - ADDR_W'(2);
        state_d  = ST_EXEC;
      end
      ST_EXEC: begin
        ram_addr = sp_q - ADDR_W'(2);
        state_d  = ST_WRITE;
      end
      ST_WRITE: begin
        ram_addr  = sp_q - ADDR_W'(2);
        ram_wdata = result_q;
        ram_we    = RESET_N;
        sp_out    = sp_q - ADDR_W'(1);
        sp_we     = RESET_N;
        state_d   = ST_DONE;
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign busy   = (state_q != ST_IDLE);
  assign error  = error_q;
  assign result = result_q;

endmodule
